// File: rtl/vga_pkg.sv
// Shared constants and state type for the VGA raster sequencer.
package vga_pkg;

  localparam int unsigned COUNT_W = 10;

  // Default 640x480 timing, pixels / lines.
  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/vga_tick_gen.sv
// Pixel-rate prescaler: one-clock pixel_tick every DIV system clocks.
// tick_en is the combinational "tick happens on this edge" strobe so the
// raster counters can update on the same edge the registered tick rises.
module vga_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick_en,
  output logic pixel_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pixel_tick_q, pixel_tick_d;

  assign tick_en    = !clear && (cnt_q == LAST);
  assign pixel_tick = pixel_tick_q;

  // Next prescaler count and registered tick.
  always_comb begin
    cnt_d        = cnt_q;
    pixel_tick_d = tick_en;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler state, cleared asynchronously on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      pixel_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pixel_tick_q <= pixel_tick_d;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: IDLE/ARM/RUN FSM, h/v counters and registered
// sync / video decodes, all updated on the pixel_tick edge.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned DIV       = 2,
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF,
  parameter int unsigned SYNC_POL  = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic               pixel_tick,
  output logic [COUNT_W-1:0] hcount,
  output logic [COUNT_W-1:0] vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_VIS    = COUNT_W'(H_VISIBLE);
  localparam logic [COUNT_W-1:0] V_VIS    = COUNT_W'(V_VISIBLE);
  localparam logic [COUNT_W-1:0] HS_FIRST = COUNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [COUNT_W-1:0] HS_LAST  = COUNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COUNT_W-1:0] VS_FIRST = COUNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [COUNT_W-1:0] VS_LAST  = COUNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic               SYNC_ACT = (SYNC_POL != 0);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] hcount_q, hcount_d;
  logic [COUNT_W-1:0] vcount_q, vcount_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               advance;
  logic               tick_en;
  logic               tick_clear;

  // Dropping enable also clears the prescaler so no tick escapes on the
  // edge where the FSM returns to IDLE.
  assign tick_clear = (state_q == IDLE) || !enable;

  vga_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clock      (clock),
    .reset      (reset),
    .clear      (tick_clear),
    .tick_en    (tick_en),
    .pixel_tick (pixel_tick)
  );

  // FSM, counter advance and decodes of the new position.
  always_comb begin
    state_d       = state_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    advance       = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) state_d = ARM;
      end
      ARM: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick_en) begin
          state_d       = RUN;
          hcount_d      = '0;
          vcount_d      = '0;
          line_start_d  = 1'b1;
          frame_start_d = 1'b1;
          advance       = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick_en) begin
          advance = 1'b1;
          if (hcount_q == H_LAST) begin
            hcount_d     = '0;
            line_start_d = 1'b1;
            if (vcount_q == V_LAST) begin
              vcount_d      = '0;
              frame_start_d = 1'b1;
            end else begin
              vcount_d = vcount_q + COUNT_W'(1);
            end
          end else begin
            hcount_d = hcount_q + COUNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      hsync_d    = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
      vsync_d    = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
      video_on_d = (hcount_d < H_VIS) && (vcount_d < V_VIS);
    end

    if (state_d == IDLE) begin
      hcount_d      = '0;
      vcount_d      = '0;
      hsync_d       = ~SYNC_ACT;
      vsync_d       = ~SYNC_ACT;
      video_on_d    = 1'b0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // Registered state and outputs, asynchronously forced to IDLE values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: default-timing instance driven from a vector
// table, plus a tiny-timing instance for whole frames and an active-high,
// DIV=4 instance for sync polarity and tick spacing.
module tb_vga_timing_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Observation vector: {pixel_tick, frame_start, line_start, video_on, vsync, hsync, vcount, hcount}
  logic       rst_a, rst_bc, en_a, en_b, en_c;
  logic       pt_a, hs_a, vs_a, vo_a, ls_a, fs_a;
  logic       pt_b, hs_b, vs_b, vo_b, ls_b, fs_b;
  logic       pt_c, hs_c, vs_c, vo_c, ls_c, fs_c;
  logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
  logic [25:0] obs_a, obs_b, obs_c;

  assign obs_a = {pt_a, fs_a, ls_a, vo_a, vs_a, hs_a, v_a, h_a};
  assign obs_b = {pt_b, fs_b, ls_b, vo_b, vs_b, hs_b, v_b, h_b};
  assign obs_c = {pt_c, fs_c, ls_c, vo_c, vs_c, hs_c, v_c, h_c};

  vga_timing_ctrl #(.DIV(2)) u_a (
    .clock(clock), .reset(rst_a), .enable(en_a), .pixel_tick(pt_a),
    .hcount(h_a), .vcount(v_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(vo_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_ctrl #(
    .DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(0)
  ) u_b (
    .clock(clock), .reset(rst_bc), .enable(en_b), .pixel_tick(pt_b),
    .hcount(h_b), .vcount(v_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(vo_b), .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_ctrl #(.DIV(4), .SYNC_POL(1)) u_c (
    .clock(clock), .reset(rst_bc), .enable(en_c), .pixel_tick(pt_c),
    .hcount(h_c), .vcount(v_c), .hsync(hs_c), .vsync(vs_c),
    .video_on(vo_c), .line_start(ls_c), .frame_start(fs_c)
  );

  typedef struct {
    bit          en;
    int unsigned n;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [25:0] mkv(int unsigned h, int unsigned v, bit hs, bit vs,
                                      bit vo, bit ls, bit fs, bit pt);
    return {pt, fs, ls, vo, vs, hs, 10'(v), 10'(h)};
  endfunction

  // Reference position and decodes for the n-th tick after the first frame_start.
  function automatic logic [25:0] model(int unsigned n, bit tick,
                                        int unsigned hv, int unsigned hf, int unsigned hsw, int unsigned hb,
                                        int unsigned vv, int unsigned vf, int unsigned vsw, int unsigned vb,
                                        bit pol);
    int unsigned ht, vt, h, v;
    bit hsa, vsa;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    h   = n % ht;
    v   = (n / ht) % vt;
    hsa = (h >= hv + hf) && (h < hv + hf + hsw);
    vsa = (v >= vv + vf) && (v < vv + vf + vsw);
    return mkv(h, v, pol ? hsa : !hsa, pol ? vsa : !vsa, (h < hv) && (v < vv),
               tick && (h == 0), tick && (h == 0) && (v == 0), tick);
  endfunction

  task automatic chk(input string nm, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [25:0] idle_lo;
  int unsigned fs_cyc0;

  initial begin
    rst_a = 1'b1; rst_bc = 1'b1;
    en_a = 1'b1; en_b = 1'b0; en_c = 1'b0;
    idle_lo = mkv(0, 0, 1, 1, 0, 0, 0, 0);

    // Default timing, DIV=2, active-low; counts are negedges to advance.
    tbl.push_back('{1, 1,    idle_lo});
    tbl.push_back('{1, 2,    mkv(0,   0, 1, 1, 1, 1, 1, 1)});
    tbl.push_back('{1, 1,    mkv(0,   0, 1, 1, 1, 0, 0, 0)});
    tbl.push_back('{1, 1277, mkv(639, 0, 1, 1, 1, 0, 0, 1)});
    tbl.push_back('{1, 2,    mkv(640, 0, 1, 1, 0, 0, 0, 1)});
    tbl.push_back('{1, 30,   mkv(655, 0, 1, 1, 0, 0, 0, 1)});
    tbl.push_back('{1, 2,    mkv(656, 0, 0, 1, 0, 0, 0, 1)});
    tbl.push_back('{1, 190,  mkv(751, 0, 0, 1, 0, 0, 0, 1)});
    tbl.push_back('{1, 2,    mkv(752, 0, 1, 1, 0, 0, 0, 1)});
    tbl.push_back('{1, 94,   mkv(799, 0, 1, 1, 0, 0, 0, 1)});
    tbl.push_back('{1, 2,    mkv(0,   1, 1, 1, 1, 1, 0, 1)});
    tbl.push_back('{1, 1,    mkv(0,   1, 1, 1, 1, 0, 0, 0)});
    tbl.push_back('{1, 599,  mkv(300, 1, 1, 1, 1, 0, 0, 1)});
    tbl.push_back('{0, 1,    idle_lo});
    tbl.push_back('{0, 3,    idle_lo});
    tbl.push_back('{1, 1,    idle_lo});
    tbl.push_back('{1, 1,    idle_lo});
    tbl.push_back('{1, 1,    mkv(0,   0, 1, 1, 1, 1, 1, 1)});

    repeat (3) @(negedge clock);
    chk("reset_state_a", obs_a, idle_lo);
    rst_a = 1'b0; rst_bc = 1'b0;

    foreach (tbl[i]) begin
      en_a = tbl[i].en;
      repeat (tbl[i].n) @(negedge clock);
      chk($sformatf("vec%0d", i), obs_a, tbl[i].exp);
    end

    // Async reset just before the 799->0 wrap: IDLE values at once, no pulse.
    repeat (1598) @(negedge clock);
    chk("pre_reset_h799", obs_a, mkv(799, 0, 1, 1, 0, 0, 0, 1));
    #2 rst_a = 1'b1;
    #1 chk("async_reset_immediate", obs_a, idle_lo);
    @(negedge clock);
    chk("reset_held_over_edge", obs_a, idle_lo);
    rst_a = 1'b0;
    @(negedge clock);
    chk("restart_arm", obs_a, idle_lo);
    repeat (2) @(negedge clock);
    chk("restart_frame_start", obs_a, mkv(0, 0, 1, 1, 1, 1, 1, 1));
    en_a = 1'b0;

    // Tiny timing, DIV=3: two whole frames plus one tick.
    en_b = 1'b1;
    repeat (4) @(negedge clock);
    for (int unsigned n = 0; n <= 240; n++) begin
      if (n > 0) begin
        for (int unsigned j = 0; j < 2; j++) begin
          @(negedge clock);
          chk($sformatf("b_hold%0d", n - 1), obs_b, model(n - 1, 0, 8, 2, 3, 2, 4, 1, 2, 1, 0));
        end
        @(negedge clock);
      end
      chk($sformatf("b_tick%0d", n), obs_b, model(n, 1, 8, 2, 3, 2, 4, 1, 2, 1, 0));
      if (n == 0) fs_cyc0 = cyc;
      if (n == 120 || n == 240) begin
        checks++;
        if (cyc - fs_cyc0 != 360) begin
          errors++;
          $display("FAIL b_frame_period%0d: got %0d expected 360", n, cyc - fs_cyc0);
        end
        fs_cyc0 = cyc;
      end
    end
    en_b = 1'b0;

    // Default timing, DIV=4, active-high: one line plus the wrap.
    en_c = 1'b1;
    repeat (5) @(negedge clock);
    for (int unsigned n = 0; n <= 800; n++) begin
      if (n > 0) begin
        for (int unsigned j = 0; j < 3; j++) begin
          @(negedge clock);
          chk($sformatf("c_hold%0d", n - 1), obs_c,
              model(n - 1, 0, 640, 16, 96, 48, 480, 10, 2, 33, 1));
        end
        @(negedge clock);
      end
      chk($sformatf("c_tick%0d", n), obs_c, model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1));
    end
    en_c = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Raster sequencer for the VGA controller. Derives a pixel-rate enable from the system clock with an internal prescaler, so no divided or derived clock is used. Sequences the horizontal and vertical counters through visible, front-porch, sync and back-porch intervals, and drives hsync, vsync and the pixel-position bus consumed by the pixel/colour datapath.

## Interface
Parameters:
- DIV, 2: system clocks per pixel; legal range 2..16.
- H_VISIBLE, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync polarity; 0 = active-low, 1 = active-high.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: reset, asynchronous, active-high.
- enable, in, 1: run request; low forces the block idle.
- pixel_tick, out, 1: one-clock pulse every DIV clocks while running.
- hcount, out, 10: current pixel column, 0..H_TOTAL-1.
- vcount, out, 10: current line, 0..V_TOTAL-1.
- hsync, out, 1: horizontal sync, polarity set by SYNC_POL.
- vsync, out, 1: vertical sync, polarity set by SYNC_POL.
- video_on, out, 1: high inside the visible region.
- line_start, out, 1: one-clock pulse when hcount becomes 0.
- frame_start, out, 1: one-clock pulse when (hcount, vcount) becomes (0, 0).

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK = 800. V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK = 525.
- FSM states:
  - IDLE: entered on reset or whenever enable is low. Prescaler = 0, hcount = vcount = 0, video_on = 0, hsync/vsync inactive (= ~SYNC_POL), all pulses 0.
  - ARM: IDLE→ARM on the first clock with enable = 1. The prescaler counts 0..DIV-1 and asserts pixel_tick when its count is DIV-1. On the first pixel_tick, load position (0,0), assert line_start and frame_start, and go to RUN.
  - RUN: on each pixel_tick:
    - hcount += 1.
    - When hcount = H_TOTAL-1: hcount ← 0, line_start pulses, vcount += 1.
    - When vcount = V_TOTAL-1 also: vcount ← 0, frame_start pulses.
  - RUN→IDLE on any clock with enable = 0, regardless of position. All outputs take IDLE values on the next edge.
- Decodes, evaluated on the new position:
  - hsync active for hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656, 751].
  - vsync active for vcount in [490, 491].
  - video_on = (hcount < H_VISIBLE) && (vcount < V_VISIBLE).
- Counter arithmetic is unsigned, 10 bits. Wrap is by compare to TOTAL-1, never by overflow.
- A reset asserted mid-frame clears everything asynchronously. Restart always begins from ARM.

## Timing
- Every output is registered. hcount, vcount, hsync, vsync, video_on, line_start and frame_start all change on the same edge as pixel_tick, so the position and its decodes are always coherent.
- pixel_tick, line_start and frame_start are each exactly one system clock wide.
- The first frame_start occurs DIV clocks after enable is first sampled high.
- Line period = H_TOTAL × DIV clocks. Frame period = H_TOTAL × V_TOTAL × DIV clocks.
- Between ticks, all outputs hold their values.

## Structure
- Shared package vga_pkg holds:
  - the COUNT_W = 10 constant;
  - the default 640x480 timing constants;
  - the state enum {IDLE, ARM, RUN}.
- One sub-module, vga_tick_gen: the DIV prescaler with a synchronous clear (driven by state == IDLE) and the pixel_tick output.
- Counter logic, FSM and decodes stay in vga_timing_ctrl.

## Test plan
- Reset with enable = 1, DIV = 2, then release → first pixel_tick and frame_start 2 clocks later; hcount = 0, vcount = 0, video_on = 1; hsync = vsync = 1 (inactive, active-low).
- Run one line → hsync low from hcount 656 through 751. hcount wraps 799→0 with line_start, and vcount becomes 1. Line spans 1600 clocks.
- Run a full frame → vsync low for vcount 490..491. frame_start recurs every 840000 clocks. video_on is low for hcount ≥ 640 or vcount ≥ 480.
- Drop enable at hcount = 300, vcount = 200 → next edge: hcount = vcount = 0, video_on = 0, syncs inactive. Reassert enable → frame_start after DIV clocks.
- Assert reset mid-line (async, between edges) → outputs reach their IDLE values immediately, with no glitch pulse on line_start or frame_start.
- SYNC_POL = 1, DIV = 4 → hsync high only for hcount 656..751; pixel_tick spacing is 4 clocks.
